// File: rtl/pipe_pkg.sv
// Shared definitions for inter-stage pipeline registers: bubble patterns,
// control-bundle field offsets and per-stage payload layouts.
package pipe_pkg;

    localparam int unsigned SLICE_CNT_W = 2;
    localparam int unsigned STAGE_CTRL_W = 8;
    localparam int unsigned STAGE_DATA_W = 96;

    // Bit offsets of the control fields inside an 8-bit control bundle
    localparam int unsigned CTRL_MEM_WR     = 7;
    localparam int unsigned CTRL_MEM_RD     = 6;
    localparam int unsigned CTRL_REG_WR     = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 4;
    localparam int unsigned CTRL_REG_DST    = 3;

    localparam logic [STAGE_CTRL_W-1:0] IFID_CTRL_BUBBLE  = 8'h00;
    localparam logic [STAGE_CTRL_W-1:0] IDEX_CTRL_BUBBLE  = 8'h00;
    localparam logic [STAGE_CTRL_W-1:0] EXMEM_CTRL_BUBBLE = 8'h00;
    localparam logic [STAGE_CTRL_W-1:0] MEMWB_CTRL_BUBBLE = 8'h00;

    typedef struct packed {
        logic       mem_wr;
        logic       mem_rd;
        logic       reg_wr;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [2:0] alu_op;
    } stage_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [15:0] pc_lo;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rsvd;
    } stage_data_t;

    // Number of valid entries in a slice from its two valid bits
    function automatic logic [SLICE_CNT_W-1:0] slice_count(input logic a, input logic b);
        return SLICE_CNT_W'(a) + SLICE_CNT_W'(b);
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One pipeline register slice: a main entry plus an optional skid entry that
// keeps the upstream ready path registered.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W      = 8,
    parameter int unsigned        DATA_W      = 96,
    parameter int unsigned        SKID        = 1,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [SLICE_CNT_W-1:0] count
);

    if (SKID != 0) begin : g_skid
        logic              main_valid, main_valid_d;
        logic [CTRL_W-1:0] main_ctrl,  main_ctrl_d;
        logic [DATA_W-1:0] main_data,  main_data_d;
        logic              skid_valid, skid_valid_d;
        logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_d;
        logic [DATA_W-1:0] skid_data,  skid_data_d;
        logic              ready_q,    ready_d;
        logic              push;

        assign push = in_valid & ready_q;

        // Main drains or is empty: refill from skid first, then from input
        always_comb begin
            main_valid_d = main_valid;
            main_ctrl_d  = main_ctrl;
            main_data_d  = main_data;
            skid_valid_d = skid_valid;
            skid_ctrl_d  = skid_ctrl;
            skid_data_d  = skid_data;
            if (flush) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = CTRL_BUBBLE;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = CTRL_BUBBLE;
            end else if (!main_valid || out_ready) begin
                if (skid_valid) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = skid_ctrl;
                    main_data_d  = skid_data;
                    skid_valid_d = 1'b0;
                    skid_ctrl_d  = CTRL_BUBBLE;
                end else if (push) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = in_ctrl;
                    main_data_d  = in_data;
                end else begin
                    main_valid_d = 1'b0;
                    main_ctrl_d  = CTRL_BUBBLE;
                end
            end else if (push) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end
            ready_d = ~skid_valid_d;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                main_valid <= 1'b0;
                main_ctrl  <= CTRL_BUBBLE;
                main_data  <= '0;
                skid_valid <= 1'b0;
                skid_ctrl  <= CTRL_BUBBLE;
                skid_data  <= '0;
                ready_q    <= 1'b1;
            end else begin
                main_valid <= main_valid_d;
                main_ctrl  <= main_ctrl_d;
                main_data  <= main_data_d;
                skid_valid <= skid_valid_d;
                skid_ctrl  <= skid_ctrl_d;
                skid_data  <= skid_data_d;
                ready_q    <= ready_d;
            end
        end

        assign in_ready  = ready_q;
        assign out_valid = main_valid;
        assign out_ctrl  = main_ctrl;
        assign out_data  = main_data;
        assign count     = slice_count(main_valid, skid_valid);
    end else begin : g_single
        logic              valid_q;
        logic [CTRL_W-1:0] ctrl_q;
        logic [DATA_W-1:0] data_q;

        // Single entry can accept whenever it is empty or being drained
        assign in_ready = ~valid_q | out_ready;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                ctrl_q  <= CTRL_BUBBLE;
                data_q  <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
                ctrl_q  <= CTRL_BUBBLE;
            end else if (in_ready) begin
                valid_q <= in_valid;
                if (in_valid) begin
                    ctrl_q <= in_ctrl;
                    data_q <= in_data;
                end else begin
                    ctrl_q <= CTRL_BUBBLE;
                end
            end
        end

        assign out_valid = valid_q;
        assign out_ctrl  = ctrl_q;
        assign out_data  = data_q;
        assign count     = slice_count(valid_q, 1'b0);
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: DEPTH chained slices with ready/valid flow
// control, synchronous flush and bubble insertion on emptied slots.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W      = 8,
    parameter int unsigned        DATA_W      = 96,
    parameter int unsigned        DEPTH       = 1,
    parameter int unsigned        SKID        = 1,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [CTRL_W-1:0]                      in_ctrl,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic                                   flush,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [CTRL_W-1:0]                      out_ctrl,
    output logic [DATA_W-1:0]                      out_data,
    output logic [$clog2(DEPTH*(SKID+1)+1)-1:0]    count
);

    localparam int unsigned CNT_W = $clog2(DEPTH*(SKID+1)+1);

    logic [DEPTH:0]          ch_valid;
    logic [DEPTH:0]          ch_ready;
    logic [CTRL_W-1:0]       ch_ctrl [DEPTH+1];
    logic [DATA_W-1:0]       ch_data [DEPTH+1];
    logic [SLICE_CNT_W-1:0]  slice_cnt [DEPTH];
    logic [CNT_W-1:0]        count_sum;

    assign ch_valid[0]     = in_valid;
    assign ch_ctrl[0]      = in_ctrl;
    assign ch_data[0]      = in_data;
    assign in_ready        = ch_ready[0];
    assign ch_ready[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        pipe_slice #(
            .CTRL_W      (CTRL_W),
            .DATA_W      (DATA_W),
            .SKID        (SKID),
            .CTRL_BUBBLE (CTRL_BUBBLE)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (ch_valid[k]),
            .in_ready  (ch_ready[k]),
            .in_ctrl   (ch_ctrl[k]),
            .in_data   (ch_data[k]),
            .out_valid (ch_valid[k+1]),
            .out_ready (ch_ready[k+1]),
            .out_ctrl  (ch_ctrl[k+1]),
            .out_data  (ch_data[k+1]),
            .count     (slice_cnt[k])
        );
    end

    // Occupancy is the sum of every slice's valid entries
    always_comb begin
        count_sum = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            count_sum = count_sum + CNT_W'(slice_cnt[k]);
        end
    end

    assign out_valid = ch_valid[DEPTH];
    assign out_ctrl  = ch_ctrl[DEPTH];
    assign out_data  = ch_data[DEPTH];
    assign count     = count_sum;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks of pipe_stage_reg in three configurations.
module tb_pipe_stage_reg;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    // A: DEPTH=2, SKID=1, bubble 00
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data, a_out_data;
    logic [2:0]  a_count;
    // B: DEPTH=1, SKID=1, bubble 3C
    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_count;
    // C: DEPTH=3, SKID=0, bubble C3
    logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
    logic [7:0]  c_in_ctrl, c_out_ctrl;
    logic [31:0] c_in_data, c_out_data;
    logic [1:0]  c_count;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .DEPTH(2), .SKID(1), .CTRL_BUBBLE(8'h00)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .count(a_count));

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .DEPTH(1), .SKID(1), .CTRL_BUBBLE(8'h3C)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .count(b_count));

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .DEPTH(3), .SKID(0), .CTRL_BUBBLE(8'hC3)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ctrl(c_in_ctrl), .in_data(c_in_data), .flush(c_flush),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl),
        .out_data(c_out_data), .count(c_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic b_push(input logic [31:0] v);
        b_in_valid = 1'b1;
        b_in_ctrl  = v[7:0];
        b_in_data  = v;
    endtask

    logic [39:0] sb [$];
    logic [39:0] exp_e;
    logic        c_pend;
    logic        push, pop;
    int          seq;
    int          n_push;

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1;
        a_in_valid = 0; a_in_ctrl = 0; a_in_data = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_ctrl = 0; b_in_data = 0; b_flush = 0; b_out_ready = 0;
        c_in_valid = 0; c_in_ctrl = 0; c_in_data = 0; c_flush = 0; c_out_ready = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_ctrl",  64'(a_out_ctrl),  64'h00);
        check("rst_a_data",  64'(a_out_data),  64'd0);
        check("rst_a_count", 64'(a_count),     64'd0);
        check("rst_a_ready", 64'(a_in_ready),  64'd1);
        check("rst_b_ctrl",  64'(b_out_ctrl),  64'h3C);
        check("rst_c_ready", 64'(c_in_ready),  64'd1);
        check("rst_c_ctrl",  64'(c_out_ctrl),  64'hC3);

        // Single push through DEPTH=2
        a_in_valid = 1; a_in_ctrl = 8'hA5; a_in_data = 32'h1234;
        @(negedge clk);
        check("a1_e1_valid", 64'(a_out_valid), 64'd0);
        check("a1_e1_count", 64'(a_count),     64'd1);
        a_in_valid = 0;
        @(negedge clk);
        check("a1_e2_valid", 64'(a_out_valid), 64'd1);
        check("a1_e2_ctrl",  64'(a_out_ctrl),  64'hA5);
        check("a1_e2_data",  64'(a_out_data),  64'h1234);
        check("a1_e2_count", 64'(a_count),     64'd1);
        @(negedge clk);
        check("a1_e3_valid", 64'(a_out_valid), 64'd0);
        check("a1_e3_ctrl",  64'(a_out_ctrl),  64'h00);
        check("a1_e3_count", 64'(a_count),     64'd0);

        // Stream of 16 back-to-back values
        for (int i = 0; i < 18; i++) begin
            a_in_valid = (i < 16);
            a_in_ctrl  = 8'(i);
            a_in_data  = 32'h100 + 32'(i);
            @(negedge clk);
            check("a2_valid", 64'(a_out_valid), 64'((i >= 1) && (i <= 16)));
            check("a2_count", 64'(a_count), 64'(int'(i < 16) + int'((i >= 1) && (i <= 16))));
            check("a2_ready", 64'(a_in_ready), 64'd1);
            if (i >= 1 && i <= 16) begin
                check("a2_data", 64'(a_out_data), 64'(32'h100 + 32'(i - 1)));
                check("a2_ctrl", 64'(a_out_ctrl), 64'(8'(i - 1)));
            end
        end
        a_in_valid = 0;

        // Skid fill with stalled output, then drain
        b_push(32'd1);
        @(negedge clk);
        check("b_p1_count", 64'(b_count), 64'd1);
        check("b_p1_ready", 64'(b_in_ready), 64'd1);
        check("b_p1_data",  64'(b_out_data), 64'd1);
        b_push(32'd2);
        @(negedge clk);
        check("b_p2_count", 64'(b_count), 64'd2);
        check("b_p2_ready", 64'(b_in_ready), 64'd0);
        check("b_p2_data",  64'(b_out_data), 64'd1);
        b_push(32'd3);
        @(negedge clk);
        check("b_p3_count", 64'(b_count), 64'd2);
        check("b_p3_ready", 64'(b_in_ready), 64'd0);
        b_out_ready = 1;
        @(negedge clk);
        check("b_d1_data",  64'(b_out_data), 64'd2);
        check("b_d1_ctrl",  64'(b_out_ctrl), 64'd2);
        check("b_d1_count", 64'(b_count), 64'd1);
        check("b_d1_ready", 64'(b_in_ready), 64'd1);
        @(negedge clk);
        check("b_d2_data",  64'(b_out_data), 64'd3);
        check("b_d2_valid", 64'(b_out_valid), 64'd1);
        check("b_d2_count", 64'(b_count), 64'd1);
        b_in_valid = 0;
        @(negedge clk);
        check("b_d3_valid", 64'(b_out_valid), 64'd0);
        check("b_d3_ctrl",  64'(b_out_ctrl), 64'h3C);
        check("b_d3_count", 64'(b_count), 64'd0);

        // Flush of a full slice with input offered
        b_out_ready = 0;
        b_push(32'h11);
        @(negedge clk);
        b_push(32'h22);
        @(negedge clk);
        check("b_f_full", 64'(b_count), 64'd2);
        b_push(32'h33);
        b_flush = 1;
        @(negedge clk);
        check("b_f_valid", 64'(b_out_valid), 64'd0);
        check("b_f_count", 64'(b_count), 64'd0);
        check("b_f_ctrl",  64'(b_out_ctrl), 64'h3C);
        check("b_f_ready", 64'(b_in_ready), 64'd1);
        b_flush = 0; b_in_valid = 0; b_out_ready = 1;
        repeat (2) begin
            @(negedge clk);
            check("b_f_gone", 64'(b_out_valid), 64'd0);
        end

        // Flush discards a transfer that would otherwise be accepted
        b_out_ready = 0;
        b_push(32'h44);
        @(negedge clk);
        check("b_g_count1", 64'(b_count), 64'd1);
        b_push(32'h55);
        b_flush = 1;
        @(negedge clk);
        check("b_g_count0", 64'(b_count), 64'd0);
        check("b_g_valid",  64'(b_out_valid), 64'd0);
        b_flush = 0; b_in_valid = 0; b_out_ready = 1;
        @(negedge clk);
        check("b_g_gone", 64'(b_out_valid), 64'd0);
        check("b_g_cnt",  64'(b_count), 64'd0);

        // Asynchronous reset mid-stream
        b_out_ready = 0;
        b_push(32'h66);
        @(negedge clk);
        b_push(32'h77);
        @(negedge clk);
        check("b_r_count", 64'(b_count), 64'd2);
        check("b_r_data",  64'(b_out_data), 64'h66);
        b_in_valid = 0;
        #2 reset = 1'b1;
        #1;
        check("b_r_valid0", 64'(b_out_valid), 64'd0);
        check("b_r_count0", 64'(b_count), 64'd0);
        check("b_r_ctrl",   64'(b_out_ctrl), 64'h3C);
        check("b_r_data0",  64'(b_out_data), 64'd0);
        check("b_r_ready",  64'(b_in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic through the combinational-ready variant
        c_pend = 0; seq = 0; n_push = 0;
        for (int i = 0; i < 1030; i++) begin
            @(negedge clk);
            c_out_ready = (i < 1000) ? ($urandom_range(0, 99) < 50) : 1'b1;
            if (!c_pend) begin
                c_in_valid = (i < 1000) ? ($urandom_range(0, 99) < 70) : 1'b0;
                if (c_in_valid) begin
                    c_in_ctrl = 8'(seq);
                    c_in_data = {16'(seq), ~16'(seq)};
                    seq++;
                end
            end
            #1;
            push = c_in_valid & c_in_ready;
            pop  = c_out_valid & c_out_ready;
            check("c_count", 64'(c_count), 64'(sb.size()));
            if (!c_out_valid) check("c_bubble", 64'(c_out_ctrl), 64'hC3);
            if (pop) begin
                if (sb.size() == 0) begin
                    check("c_spurious", 64'(c_out_valid), 64'd0);
                end else begin
                    exp_e = sb.pop_front();
                    check("c_data", {c_out_ctrl, c_out_data}, 64'(exp_e));
                end
            end
            if (push) begin
                sb.push_back({c_in_ctrl, c_in_data});
                n_push++;
            end
            c_pend = c_in_valid & ~push;
        end
        check("c_drained",  64'(sb.size()), 64'd0);
        check("c_cnt_end",  64'(c_count), 64'd0);
        check("c_activity", 64'(n_push > 300), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
